// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the value written to HI/LO when a divide cannot produce a result.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic [31:0] RESULT_INVALID = 32'hdeadbeef;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate. Used both to take operand magnitudes
// and to restore the sign of results after the unsigned iteration.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the HI/LO registers.
// One multiply or divide step per clock over a shared 2*WIDTH accumulator.
// Optional feature macro: MULDIV_DIV_EN enables the divide datapath; without
// it DIV/DIVU take the invalid-result path (HI=LO=0xdeadbeef after one edge).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic             start,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] INVALID_W = WIDTH'(RESULT_INVALID);

  state_e state;
  logic [CW-1:0] cnt;
  logic inv_p0;

  logic [2*WIDTH-1:0] acc_p0;
  logic [WIDTH-1:0] mag_b_p0;
  logic neg_q_p0;

  logic op_mul, op_div, op_signed, sign_a, sign_b, div_ok, div_inv;
  logic signed [WIDTH-1:0] a_sgn, b_sgn;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0] mul_sum;
  logic [2*WIDTH-1:0] mul_next, acc_step, prod_fix;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_sgn     = A;
  assign b_sgn     = B;
  assign sign_a    = op_signed && (a_sgn < 0);
  assign sign_b    = op_signed && (b_sgn < 0);

  muldiv_signfix #(.W(WIDTH)) u_abs_a (.din(A), .neg(sign_a), .dout(abs_a));
  muldiv_signfix #(.W(WIDTH)) u_abs_b (.din(B), .neg(sign_b), .dout(abs_b));

  // Shift-add: add multiplicand into the upper half when the LSB is set,
  // then shift the whole accumulator right (carry enters the MSB).
  assign mul_sum  = {1'b0, acc_p0[2*WIDTH-1:WIDTH]} + {1'b0, mag_b_p0};
  assign mul_next = acc_p0[0] ? {mul_sum, acc_p0[WIDTH-1:1]}
                              : {1'b0, acc_p0[2*WIDTH-1:1]};

  muldiv_signfix #(.W(2*WIDTH)) u_prod_fix (.din(acc_p0), .neg(neg_q_p0), .dout(prod_fix));

`ifdef MULDIV_DIV_EN
  logic is_mul_p0, neg_r_p0;
  logic [WIDTH:0] div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Restoring divide: accumulator holds {remainder, dividend/quotient};
  // trial-subtract the divisor from the shifted remainder, keep it if >= 0.
  assign div_trial = acc_p0[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b_p0};
  assign div_next  = div_trial[WIDTH] ? {acc_p0[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_p0[WIDTH-2:0], 1'b1};
  assign acc_step  = is_mul_p0 ? mul_next : div_next;
  assign div_ok    = op_div && (B != '0);
  assign div_inv   = op_div && (B == '0);

  muldiv_signfix #(.W(WIDTH)) u_quo_fix (.din(acc_p0[WIDTH-1:0]),       .neg(neg_q_p0), .dout(quo_fix));
  muldiv_signfix #(.W(WIDTH)) u_rem_fix (.din(acc_p0[2*WIDTH-1:WIDTH]), .neg(neg_r_p0), .dout(rem_fix));

  assign res_hi = inv_p0 ? INVALID_W : (is_mul_p0 ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix);
  assign res_lo = inv_p0 ? INVALID_W : (is_mul_p0 ? prod_fix[WIDTH-1:0] : quo_fix);
`else
  assign acc_step = mul_next;
  assign div_ok   = 1'b0;
  assign div_inv  = op_div;
  assign res_hi   = inv_p0 ? INVALID_W : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = inv_p0 ? INVALID_W : prod_fix[WIDTH-1:0];
`endif

  // Datapath: capture magnitudes and result signs at issue, step during RUN
  always_ff @(posedge clk) begin
    if (state == IDLE && start && (op_mul || div_ok)) begin
      acc_p0   <= {{WIDTH{1'b0}}, abs_a};
      mag_b_p0 <= abs_b;
      neg_q_p0 <= sign_a ^ sign_b;
`ifdef MULDIV_DIV_EN
      is_mul_p0 <= op_mul;
      neg_r_p0  <= sign_a;
`endif
    end else if (state == RUN) begin
      acc_p0 <= acc_step;
    end
  end

  // Control FSM and architectural HI/LO registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      inv_p0 <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              hi <= A;
            end else if (op == OP_MTLO) begin
              lo <= A;
            end else if (div_inv) begin
              inv_p0 <= 1'b1;
              state  <= FIX;
            end else if (op_mul || div_ok) begin
              inv_p0 <= 1'b0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the execute stage of the MIPS datapath. Takes the same rs/rt operands as the ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, which the ALU does not handle. Results go into the architectural HI/LO registers, whose outputs drive the writeback mux for MFHI/MFLO. `busy` stalls the pipeline while an operation is in flight.

## Interface
- `WIDTH`, default 32: operand width; also the iteration count.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `A` in WIDTH: rs operand.
- `B` in WIDTH: rt operand.
- `op` in 3: operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- `start` in 1: `op` is valid this cycle.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.
- `busy` out 1: an operation is in progress; the pipeline must stall.
- `done` out 1: one-cycle pulse when HI/LO have just been updated by MULT/DIV.

## Operation
- States: IDLE, RUN, FIX.
- IDLE behaviour when `start`=1:
  - MTHI: `hi`<=A. MTLO: `lo`<=A. Both take one edge; `busy` stays 0; no `done`.
  - MULT/MULTU/DIV/DIVU: latch the operand magnitudes (absolute values for signed ops, raw values for unsigned) and the result signs, clear the iteration counter, go to RUN, set `busy`=1.
  - DIV/DIVU with B==0: no RUN. Next edge writes `hi`=`lo`=32'hdeadbeef, pulses `done`, stays IDLE.
- RUN performs WIDTH iterations, one per edge:
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - After the WIDTH-th iteration, go to FIX.
- FIX, on one edge:
  - Multiply: negate the 64-bit product if the sign bits of A and B differ.
  - Divide: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
  - Write HI = product[63:32] or remainder; LO = product[31:0] or quotient.
  - `done`<=1, `busy`<=0, go to IDLE.
- Arithmetic rules:
  - Unsigned ops never negate.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (the wrapped negation is kept; no exception).
- `start` while `busy`=1 is ignored, including MTHI/MTLO. The issuing stage must hold the instruction until `busy`=0.
- HI/LO are not modified during RUN. `hi`/`lo` show the previous values until the FIX edge.

## Timing
- Reset (`rst_n`=0 at an edge), including mid-operation: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0. In-flight operation discarded.
- MULT/DIV latency:
  - `start` sampled at edge E0; `busy`=1 from E0 until E(WIDTH+1).
  - Results and `done` are visible after E(WIDTH+1): 33 cycles for WIDTH=32.
  - `done` lasts exactly one cycle.
- Back-to-back: `start` may be asserted in the cycle where `done`=1. It is accepted at the next edge.
- Divide by zero: `done` is visible after E1; `busy` never rises.
- MTHI/MTLO: new value visible after E0+1 edge, i.e. the cycle after `start`.

## Configuration
- Macro: `MULDIV_DIV_EN`.
- Defined: DIV/DIVU behave as described above.
- Undefined:
  - Divide datapath is removed.
  - Ops 010/011 take the divide-by-zero path: `hi`=`lo`=32'hdeadbeef and `done` after one edge.
  - MULT/MULTU/MTHI/MTLO are unchanged.

## Structure
- Package `muldiv_pkg`:
  - op encodings (OP_MULT … OP_MTLO)
  - state enum (IDLE/RUN/FIX)
  - constant RESULT_INVALID = 32'hdeadbeef
- Sub-module `muldiv_signfix`: combinational conditional two's-complement negate with a parameterised width. Instantiated for operand absolute values and for the FIX-stage sign correction.

## Test plan
- MULT A=0xFFFFFFFD (-3), B=5 -> `done` 33 cycles after `start`; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1; `busy` high for exactly 33 cycles.
- MULTU A=B=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU A=7, B=0 -> `done` one cycle after `start`, `hi`=`lo`=0xDEADBEEF, `busy` stays 0. With `MULDIV_DIV_EN` undefined, DIVU 7/2 gives the same result.
- MTHI A=0x12345678 -> `hi` updates the next cycle, no `done`. Start MULT, then assert MTLO at cycle 5 of RUN -> ignored, and `lo` equals the product after `done`.
- MULT in progress, `rst_n`=0 at cycle 10 -> next cycle `hi`=`lo`=0, `busy`=0, `done`=0. No late `done` after reset is released.
